// File: rtl/conv2_buf_5ks_if.sv
// Pixel stream in, 5x5 window out: the bus between the pooled feature-map source,
// the conv2 window buffer and the conv2 calculation stage.
interface conv2_buf_5ks_if #(
    parameter int unsigned DATA_BITS = 12
);
    logic                 valid_in;
    logic [DATA_BITS-1:0] data_in;
    logic [DATA_BITS-1:0] out_data [25];
    logic                 valid_out;
    logic                 frame_done;

    modport master (
        output valid_in, data_in,
        input  out_data, valid_out, frame_done
    );

    modport slave (
        input  valid_in, data_in,
        output out_data, valid_out, frame_done
    );
endinterface

// File: rtl/conv2_buf_5ks.sv
// Streaming 5x5 window generator: shift-register line buffer over a raster pixel stream,
// emitting one registered window per accepted pixel at row >= 4 and col >= 4.
module conv2_buf_5ks #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned HEIGHT    = 12,
    parameter int unsigned DATA_BITS = 12
) (
    input logic            clk,
    input logic            rst,
    conv2_buf_5ks_if.slave bus
);
    localparam int unsigned LEN      = 4 * WIDTH + 5;
    localparam int unsigned COL_BITS = $clog2(WIDTH);
    localparam int unsigned ROW_BITS = $clog2(HEIGHT);

    logic [DATA_BITS-1:0] line_q [LEN];
    // tap[k] is the pixel accepted k pixels before the one on data_in
    logic [DATA_BITS-1:0] tap    [LEN];
    logic [DATA_BITS-1:0] win_d  [25];
    logic [DATA_BITS-1:0] win_q  [25];
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic                 col_last, row_last, win_hit;
    logic                 valid_q, done_q;

    assign tap[0] = bus.data_in;
    for (genvar k = 1; k < LEN; k++) begin : g_tap
        assign tap[k] = line_q[k-1];
    end

    for (genvar r = 0; r < 5; r++) begin : g_row
        for (genvar c = 0; c < 5; c++) begin : g_col
            assign win_d[5*r+c] = tap[(4-r)*WIDTH + (4-c)];
        end
    end

    always_comb begin
        col_last = (col_q == COL_BITS'(WIDTH - 1));
        row_last = (row_q == ROW_BITS'(HEIGHT - 1));
        win_hit  = bus.valid_in && (col_q >= COL_BITS'(4)) && (row_q >= ROW_BITS'(4));
        col_d    = col_q;
        row_d    = row_q;
        if (bus.valid_in) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < LEN; i++) line_q[i] <= '0;
            for (int unsigned i = 0; i < 25; i++) win_q[i] <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= win_hit;
            done_q  <= bus.valid_in && col_last && row_last;
            if (bus.valid_in) begin
                line_q[0] <= bus.data_in;
                for (int unsigned i = 1; i < LEN; i++) line_q[i] <= line_q[i-1];
            end
            if (win_hit) begin
                win_q <= win_d;
            end
        end
    end

    assign bus.out_data   = win_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_conv2_buf_5ks.sv
// Self-checking bench for conv2_buf_5ks: raster frames (patterned and random, with and
// without idle gaps) against a window list computed directly from the frame array.
module tb_conv2_buf_5ks;
    localparam int W    = 12;
    localparam int H    = 12;
    localparam int DB   = 12;
    localparam int NWIN = (H - 4) * (W - 4);

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    conv2_buf_5ks_if #(.DATA_BITS(DB)) bus ();

    conv2_buf_5ks #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DB-1:0]      frame [H][W];
    logic [25*DB-1:0]   exp_win [$];
    bit                 exp_fd  [$];
    logic [25*DB-1:0]   got_win [$];
    bit                 got_fd  [$];
    int                 got_cyc [$];
    logic [25*DB-1:0]   saved_cont [$];
    int                 fd_stray  = 0;
    int                 gap_viol  = 0;
    int                 acc52_cyc = 0;
    bit                 acc_now   = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        acc_now <= bus.valid_in && !rst;
    end

    // Capture every window; a valid_out must follow an accept edge directly
    always @(negedge clk) begin
        if (bus.frame_done && !bus.valid_out) fd_stray++;
        if (bus.valid_out) begin
            got_win.push_back(out_vec());
            got_fd.push_back(bus.frame_done);
            got_cyc.push_back(cyc);
            if (!acc_now) gap_viol++;
        end
    end

    function automatic logic [25*DB-1:0] out_vec();
        logic [25*DB-1:0] v;
        for (int k = 0; k < 25; k++) v[k*DB +: DB] = bus.out_data[k];
        return v;
    endfunction

    function automatic void fill_pattern(input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame[r][c] = DB'(base + r * W + c);
    endfunction

    function automatic void fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) frame[r][c] = DB'($urandom);
    endfunction

    // Reference: every 5x5 patch with bottom-right at (r,c), r,c >= 4, in raster order
    function automatic void build_expected();
        logic [25*DB-1:0] v;
        for (int r = 4; r < H; r++) begin
            for (int c = 4; c < W; c++) begin
                for (int k = 0; k < 25; k++) v[k*DB +: DB] = frame[r-4+k/5][c-4+k%5];
                exp_win.push_back(v);
                exp_fd.push_back(r == H - 1 && c == W - 1);
            end
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (got_win.size() < exp_win.size()) ? got_win.size() : exp_win.size();
        for (int i = 0; i < n; i++)
            if (got_win[i] !== exp_win[i] || got_fd[i] !== exp_fd[i]) return i;
        if (got_win.size() != exp_win.size()) return n;
        return -1;
    endfunction

    function automatic int fd_count();
        int n = 0;
        foreach (got_fd[i]) n += int'(got_fd[i]);
        return n;
    endfunction

    function automatic void clear_all();
        got_win.delete();
        got_fd.delete();
        got_cyc.delete();
        exp_win.delete();
        exp_fd.delete();
        fd_stray = 0;
        gap_viol = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int max_gap, input int npix);
        int n = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int gap;
                if (n >= npix) break;
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                bus.valid_in = 1'b0;
                bus.data_in  = DB'($urandom);
                repeat (gap) tick();
                bus.valid_in = 1'b1;
                bus.data_in  = frame[r][c];
                tick();
                if (r == 4 && c == 4) acc52_cyc = cyc;
                n++;
            end
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        tick();
        tick();
        total++; if (bus.valid_out !== 1'b0) begin bad++;
            $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        total++; if (bus.frame_done !== 1'b0) begin bad++;
            $display("FAIL reset_done: got %b want 0", bus.frame_done); end
        total++; if (out_vec() !== '0) begin bad++;
            $display("FAIL reset_data: got %h want 0", out_vec()); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_continuous();
        logic [25*DB-1:0] first, last;
        int d;
        clear_all();
        fill_pattern(0);
        build_expected();
        send_frame(0, H * W);
        repeat (4) tick();
        first = (got_win.size() > 0) ? got_win[0] : 'x;
        last  = (got_win.size() > 0) ? got_win[got_win.size()-1] : 'x;
        total++; if (got_win.size() !== NWIN) begin bad++;
            $display("FAIL cont_count: got %0d want %0d", got_win.size(), NWIN); end
        total++; if (got_cyc.size() == 0 || got_cyc[0] !== acc52_cyc) begin bad++;
            $display("FAIL cont_latency: got cyc %0d want %0d",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, acc52_cyc); end
        total++; if (first[0 +: DB] !== 12'd0 || first[4*DB +: DB] !== 12'd4 ||
                     first[12*DB +: DB] !== 12'd26 || first[20*DB +: DB] !== 12'd48 ||
                     first[24*DB +: DB] !== 12'd52) begin bad++;
            $display("FAIL cont_first_window: got %h", first); end
        total++; if (last[0 +: DB] !== 12'd91 || last[24*DB +: DB] !== 12'd143) begin bad++;
            $display("FAIL cont_last_window: got out0=%0d out24=%0d want 91 143",
                     last[0 +: DB], last[24*DB +: DB]); end
        total++; if (got_fd.size() == 0 || got_fd[got_fd.size()-1] !== 1'b1) begin bad++;
            $display("FAIL cont_frame_done_last: got missing want 1"); end
        total++; if (fd_count() !== 1 || fd_stray !== 0) begin bad++;
            $display("FAIL cont_frame_done_once: got %0d (stray %0d) want 1", fd_count(),
                     fd_stray); end
        d = first_diff();
        total++; if (d !== -1) begin bad++;
            $display("FAIL cont_windows: first bad window %0d want none", d); end
        total++; if (gap_viol !== 0) begin bad++;
            $display("FAIL cont_valid_timing: got %0d bad pulses want 0", gap_viol); end
        saved_cont = got_win;
    endtask

    task automatic test_gaps();
        int d;
        clear_all();
        fill_pattern(0);
        build_expected();
        send_frame(3, H * W);
        repeat (4) tick();
        d = first_diff();
        total++; if (d !== -1) begin bad++;
            $display("FAIL gaps_windows: first bad window %0d want none", d); end
        total++; if (got_win != saved_cont) begin bad++;
            $display("FAIL gaps_vs_continuous: got %0d windows want %0d identical",
                     got_win.size(), saved_cont.size()); end
        total++; if (gap_viol !== 0) begin bad++;
            $display("FAIL gaps_valid_in_gap: got %0d want 0", gap_viol); end
    endtask

    task automatic test_back_to_back();
        logic [25*DB-1:0] second;
        int d;
        clear_all();
        fill_pattern(0);
        build_expected();
        send_frame(0, H * W);
        fill_pattern(1000);
        build_expected();
        send_frame(0, H * W);
        repeat (4) tick();
        second = (got_win.size() > NWIN) ? got_win[NWIN] : 'x;
        total++; if (got_win.size() !== 2 * NWIN) begin bad++;
            $display("FAIL b2b_count: got %0d want %0d", got_win.size(), 2 * NWIN); end
        total++; if (second[0 +: DB] !== 12'd1000 || second[24*DB +: DB] !== 12'd1052) begin
            bad++;
            $display("FAIL b2b_second_first: got out0=%0d out24=%0d want 1000 1052",
                     second[0 +: DB], second[24*DB +: DB]); end
        d = first_diff();
        total++; if (d !== -1) begin bad++;
            $display("FAIL b2b_windows: first bad window %0d want none", d); end
        total++; if (fd_count() !== 2 || fd_stray !== 0) begin bad++;
            $display("FAIL b2b_frame_done: got %0d (stray %0d) want 2", fd_count(), fd_stray); end
    endtask

    task automatic test_reset_mid_frame();
        fill_pattern(0);
        send_frame(0, 70);
        rst          = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = DB'($urandom);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                rst          = 1'b0;
                bus.valid_in = 1'b0;
            end
            tick();
            total++; if (bus.valid_out !== 1'b0 || out_vec() !== '0) begin bad++;
                $display("FAIL midrst_outputs_%0d: got valid=%b data=%h want 0", i,
                         bus.valid_out, out_vec()); end
        end
        clear_all();
        send_frame(0, H * W);
        repeat (4) tick();
        total++; if (got_win != saved_cont) begin bad++;
            $display("FAIL midrst_replay: got %0d windows want %0d identical",
                     got_win.size(), saved_cont.size()); end
        total++; if (got_cyc.size() == 0 || got_cyc[0] !== acc52_cyc) begin bad++;
            $display("FAIL midrst_latency: got cyc %0d want %0d",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, acc52_cyc); end
    endtask

    task automatic test_rst_priority();
        int d;
        clear_all();
        fill_random();
        build_expected();
        fill_pattern(0);
        send_frame(0, 30);
        fill_random();
        exp_win.delete();
        exp_fd.delete();
        build_expected();
        rst          = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 12'hFFF;
        tick();
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        total++; if (out_vec() !== '0 || bus.valid_out !== 1'b0) begin bad++;
            $display("FAIL prio_cleared: got %h want 0", out_vec()); end
        tick();
        clear_all();
        build_expected();
        send_frame(2, H * W);
        repeat (4) tick();
        d = first_diff();
        total++; if (d !== -1) begin bad++;
            $display("FAIL prio_random_windows: first bad window %0d want none", d); end
        total++; if (fd_count() !== 1 || gap_viol !== 0) begin bad++;
            $display("FAIL prio_frame_done: got %0d (timing %0d) want 1", fd_count(),
                     gap_viol); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        test_rst_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
